cv_x_if_coproc_mux: RTL

Parametrised CORE-V-XIF fan-out that connects one core-side X-interface to NUM_COPROC coprocessors, such as an FPU subsystem plus further accelerators. It routes each offloaded instruction to one owner and tracks in-flight IDs per owner. It routes commit only to the owner and arbitrates results back to the core round-robin. It replaces the fixed one-core/one-coprocessor pairing, with outstanding-limit back-pressure and protocol-error detection.

---
 rtl/cv_x_if_coproc_mux.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/cv_x_if_coproc_mux.sv
// Fans one CORE-V-XIF issue/commit/result interface out to NUM_COPROC coprocessors,
// tracking the owner of every in-flight ID and arbitrating results round-robin.
module cv_x_if_coproc_mux #(
    parameter int NUM_COPROC      = 2,
    parameter int ID_WIDTH        = 4,
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 4,
    localparam int SRC_W          = (NUM_COPROC > 1) ? $clog2(NUM_COPROC) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           x_issue_valid_i,
    output logic                           x_issue_ready_o,
    input  logic [ID_WIDTH-1:0]            x_issue_id_i,
    output logic                           x_issue_accept_o,
    output logic                           x_issue_writeback_o,
    output logic [NUM_COPROC-1:0]          cp_issue_valid_o,
    input  logic [NUM_COPROC-1:0]          cp_issue_ready_i,
    input  logic [NUM_COPROC-1:0]          cp_issue_accept_i,
    input  logic [NUM_COPROC-1:0]          cp_issue_writeback_i,
    input  logic                           x_commit_valid_i,
    input  logic [ID_WIDTH-1:0]            x_commit_id_i,
    input  logic                           x_commit_kill_i,
    output logic [NUM_COPROC-1:0]          cp_commit_valid_o,
    input  logic [NUM_COPROC-1:0]          cp_result_valid_i,
    output logic [NUM_COPROC-1:0]          cp_result_ready_o,
    input  logic [NUM_COPROC*ID_WIDTH-1:0] cp_result_id_i,
    input  logic [NUM_COPROC*XLEN-1:0]     cp_result_data_i,
    input  logic [NUM_COPROC*5-1:0]        cp_result_rd_i,
    output logic                           x_result_valid_o,
    input  logic                           x_result_ready_i,
    output logic [ID_WIDTH-1:0]            x_result_id_o,
    output logic [XLEN-1:0]                x_result_data_o,
    output logic [4:0]                     x_result_rd_o,
    output logic [SRC_W-1:0]               x_result_src_o,
    output logic                           err_o
);
    localparam int DEPTH = 2 ** ID_WIDTH;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [DEPTH-1:0] tv_q, tv_d, twb_q, twb_d;
    logic [SRC_W-1:0] town_q [DEPTH];
    logic [SRC_W-1:0] town_d [DEPTH];
    logic [CNT_W-1:0] cnt_q [NUM_COPROC];
    logic [CNT_W-1:0] cnt_d [NUM_COPROC];
    logic [SRC_W-1:0] ptr_q, ptr_d, gnt_q, gnt_d;
    logic             lock_q, lock_d, err_q, err_d;

    logic [NUM_COPROC-1:0] full, civ;
    logic [SRC_W-1:0]      gnt, idx, owner;
    logic                  found, res_hs, res_ok, res_free, com_hit, com_free;
    logic                  dup, all_rdy, has_owner, wb, alloc;

    // Result arbitration: a stalled grant stays locked so the core sees stable data.
    always_comb begin
        gnt   = gnt_q;
        idx   = '0;
        found = 1'b0;
        if (lock_q) begin
            found = cp_result_valid_i[gnt_q];
        end else begin
            for (int i = 1; i <= NUM_COPROC; i++) begin
                idx = SRC_W'((int'(ptr_q) + i) % NUM_COPROC);
                if (!found && cp_result_valid_i[idx]) begin
                    gnt   = idx;
                    found = 1'b1;
                end
            end
        end
        x_result_valid_o  = found;
        x_result_src_o    = gnt;
        x_result_id_o     = '0;
        x_result_data_o   = '0;
        x_result_rd_o     = '0;
        cp_result_ready_o = '0;
        for (int k = 0; k < NUM_COPROC; k++) begin
            if (gnt == SRC_W'(k)) begin
                x_result_id_o        = cp_result_id_i[k*ID_WIDTH +: ID_WIDTH];
                x_result_data_o      = cp_result_data_i[k*XLEN +: XLEN];
                x_result_rd_o        = cp_result_rd_i[k*5 +: 5];
                cp_result_ready_o[k] = found & x_result_ready_i;
            end
        end
        res_hs   = found & x_result_ready_i;
        res_ok   = tv_q[x_result_id_o] & (town_q[x_result_id_o] == gnt);
        res_free = res_hs & res_ok;
    end

    // Commit and issue routing; a same-cycle free of the issued ID clears the dup.
    always_comb begin
        com_hit  = x_commit_valid_i & tv_q[x_commit_id_i];
        com_free = com_hit & (x_commit_kill_i | ~twb_q[x_commit_id_i])
                   & ~(res_free & (x_result_id_o == x_commit_id_i));
        dup = tv_q[x_issue_id_i]
              & ~(com_free & (x_commit_id_i == x_issue_id_i))
              & ~(res_free & (x_result_id_o == x_issue_id_i));
        all_rdy   = 1'b1;
        has_owner = 1'b0;
        owner     = '0;
        wb        = 1'b0;
        for (int k = 0; k < NUM_COPROC; k++) begin
            full[k] = (cnt_q[k] == CNT_W'(MAX_OUTSTANDING));
            civ[k]  = x_issue_valid_i & ~full[k] & ~dup;
            cp_commit_valid_o[k] = com_hit & (town_q[x_commit_id_i] == SRC_W'(k));
            all_rdy = all_rdy & (cp_issue_ready_i[k] | full[k]);
            if (!has_owner && civ[k] && cp_issue_accept_i[k]) begin
                has_owner = 1'b1;
                owner     = SRC_W'(k);
                wb        = cp_issue_writeback_i[k];
            end
        end
        cp_issue_valid_o    = civ;
        x_issue_ready_o     = dup | all_rdy;
        x_issue_accept_o    = has_owner;
        x_issue_writeback_o = wb;
        alloc = x_issue_valid_i & x_issue_ready_o & has_owner;
    end

    // Frees are applied before allocation so a recycled ID ends up valid.
    always_comb begin
        tv_d   = tv_q;
        twb_d  = twb_q;
        town_d = town_q;
        if (com_free) tv_d[x_commit_id_i] = 1'b0;
        if (res_free) tv_d[x_result_id_o] = 1'b0;
        if (alloc) begin
            tv_d[x_issue_id_i]   = 1'b1;
            twb_d[x_issue_id_i]  = wb;
            town_d[x_issue_id_i] = owner;
        end
        for (int k = 0; k < NUM_COPROC; k++) begin
            cnt_d[k] = cnt_q[k];
            if (alloc && owner == SRC_W'(k))
                cnt_d[k] = cnt_d[k] + CNT_W'(1);
            if (com_free && town_q[x_commit_id_i] == SRC_W'(k) && cnt_d[k] != '0)
                cnt_d[k] = cnt_d[k] - CNT_W'(1);
            if (res_free && gnt == SRC_W'(k) && cnt_d[k] != '0)
                cnt_d[k] = cnt_d[k] - CNT_W'(1);
        end
        ptr_d  = res_hs ? gnt : ptr_q;
        gnt_d  = gnt;
        lock_d = found & ~x_result_ready_i;
        err_d  = (x_issue_valid_i & dup) | (x_commit_valid_i & ~tv_q[x_commit_id_i])
                 | (res_hs & ~res_ok);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tv_q   <= '0;
            twb_q  <= '0;
            for (int i = 0; i < DEPTH; i++) town_q[i] <= '0;
            for (int k = 0; k < NUM_COPROC; k++) cnt_q[k] <= '0;
            ptr_q  <= SRC_W'(NUM_COPROC - 1);
            gnt_q  <= '0;
            lock_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            tv_q   <= tv_d;
            twb_q  <= twb_d;
            town_q <= town_d;
            cnt_q  <= cnt_d;
            ptr_q  <= ptr_d;
            gnt_q  <= gnt_d;
            lock_q <= lock_d;
            err_q  <= err_d;
        end
    end

    assign err_o = err_q;
endmodule
